// File: rtl/anc_pkg.sv
// Shared definitions for the audio receive path: default converter/datapath
// widths and the serial receiver state encoding.
package anc_pkg;

    localparam int ADC_W = 16;
    localparam int DP_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchroniser for one asynchronous input, with a rising-edge
// strobe derived from the synchronised level.
module sig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pcm_rx_widen.sv
// I2S-style serial PCM receiver: deserialises IN_W-bit words, sign-extends
// them to OUT_W and hands them out over valid/ready. Define PCM_RX_FIFO_EN
// to replace the single output register with a 2-entry FIFO.
module pcm_rx_widen
    import anc_pkg::*;
#(
    parameter int IN_W  = ADC_W,
    parameter int OUT_W = DP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ws,
    input  logic             sd,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovr_err,
    output logic             frm_err
);

    localparam int CNT_W = $clog2(IN_W);

    logic w_sck, w_sck_rise, w_ws, w_ws_rise, w_sd, w_sd_rise;
    logic w_unused;

    sig_sync u_sync_sck (.clk(clk), .rst_n(rst_n), .i_sig(sck), .o_sync(w_sck), .o_rise(w_sck_rise));
    sig_sync u_sync_ws  (.clk(clk), .rst_n(rst_n), .i_sig(ws),  .o_sync(w_ws),  .o_rise(w_ws_rise));
    sig_sync u_sync_sd  (.clk(clk), .rst_n(rst_n), .i_sig(sd),  .o_sync(w_sd),  .o_rise(w_sd_rise));

    assign w_unused = ^{w_sck, w_ws_rise, w_sd_rise};

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-2:0]  r_shift;
    logic             r_ch;
    logic             r_ws_last;
    logic             r_armed;
    logic             r_frm_err;

    logic             w_ws_chg;
    logic             w_last_bit;
    logic             w_word_done;
    logic [IN_W-1:0]  w_word;
    logic [OUT_W-1:0] w_ext;

    // The first sck edge after reset only learns the ws level, so a ws that
    // was already high is not mistaken for a frame start.
    assign w_ws_chg    = r_armed & (w_ws ^ r_ws_last);
    assign w_last_bit  = (r_cnt == CNT_W'(IN_W - 1));
    assign w_word_done = w_sck_rise & (r_state == ST_SHIFT) & w_last_bit;
    assign w_word      = {r_shift, w_sd};
    assign w_ext       = OUT_W'($signed(w_word));

    // The bit sampled on a ws-change edge is the LSB of the outgoing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ch      <= 1'b0;
            r_ws_last <= 1'b0;
            r_armed   <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_frm_err <= 1'b0;
            if (w_sck_rise) begin
                r_armed   <= 1'b1;
                r_ws_last <= w_ws;
                case (r_state)
                    ST_IDLE, ST_HOLD: begin
                        if (w_ws_chg) begin
                            r_state <= ST_SHIFT;
                            r_cnt   <= '0;
                            r_ch    <= w_ws;
                        end
                    end
                    ST_SHIFT: begin
                        r_shift <= w_word[IN_W-2:0];
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                        end
                        if (w_ws_chg) begin
                            r_frm_err <= ~w_last_bit;
                            r_state   <= ST_SHIFT;
                            r_cnt     <= '0;
                            r_ch      <= w_ws;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign frm_err = r_frm_err;

`ifdef PCM_RX_FIFO_EN
    logic [OUT_W-1:0] r_mem_data [2];
    logic             r_mem_ch   [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ovr_err;
    logic             w_pop;
    logic             w_full;
    logic             w_push;

    assign w_pop  = (r_count != 2'd0) & out_ready;
    assign w_full = (r_count == 2'd2);
    assign w_push = w_word_done & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_ch[0]   <= 1'b0;
            r_mem_ch[1]   <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_ovr_err     <= 1'b0;
        end else begin
            r_ovr_err <= w_word_done & w_full & ~w_pop;
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_ext;
                r_mem_ch[r_wr_ptr]   <= r_ch;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_ch    = r_mem_ch[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign ovr_err   = r_ovr_err;
`else
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ch;
    logic             r_out_valid;
    logic             r_ovr_err;
    logic             w_pop;

    assign w_pop = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_ovr_err <= 1'b0;
            if (w_word_done) begin
                if (!r_out_valid || w_pop) begin
                    r_out_data  <= w_ext;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                end else begin
                    r_ovr_err <= 1'b1;
                end
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign ovr_err   = r_ovr_err;
`endif

endmodule

// File: tb/tb_pcm_rx_widen.sv
// Directed bench for pcm_rx_widen: drives I2S frames bit by bit with sck at
// 8 clk per bit and checks captured words and error pulses.
module tb_pcm_rx_widen;

    logic        clk;
    logic        rst_n;
    logic        sck;
    logic        ws;
    logic        sd;
    logic [16:0] out_data;
    logic        out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        ovr_err;
    logic        frm_err;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;
    int frm_cnt  = 0;
    logic [31:0] q_data [$];
    logic [31:0] q_ch   [$];

    pcm_rx_widen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovr_err  (ovr_err),
        .frm_err  (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_data.push_back({15'd0, out_data});
                q_ch.push_back({31'd0, out_ch});
            end
            if (ovr_err) ovr_cnt++;
            if (frm_err) frm_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 1: check 1-clk latency after the detected edge; mode 2: pulse
    // out_ready exactly in the cycle the word completes.
    task automatic sck_bit(input logic ws_v, input logic sd_v, input int mode);
        sck = 1'b0;
        ws  = ws_v;
        sd  = sd_v;
        repeat (4) tick();
        sck = 1'b1;
        tick();
        tick();
        if (mode == 1) chk("lat_pre", {31'd0, out_valid}, 32'd0);
        if (mode == 2) out_ready = 1'b1;
        tick();
        if (mode == 1) chk("lat_post", {31'd0, out_valid}, 32'd1);
        if (mode == 2) out_ready = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic ch, input logic [15:0] w, input int last_mode);
        sck_bit(ch, 1'b0, 0);
        for (int i = 15; i >= 0; i--) begin
            sck_bit(ch, w[i], (i == 0) ? last_mode : 0);
        end
        sck_bit(ch, 1'b0, 0);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp_d, input logic [31:0] exp_c);
        logic [31:0] d;
        logic [31:0] c;
        d = 32'hFFFF_FFFF;
        c = 32'hFFFF_FFFF;
        if (q_data.size() > 0) begin
            d = q_data.pop_front();
            c = q_ch.pop_front();
        end
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_ch"}, c, exp_c);
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_ch.delete();
        ovr_cnt = 0;
        frm_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        sck       = 1'b0;
        ws        = 1'b1;
        sd        = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {15'd0, out_data}, 32'd0);
        chk("rst_ch", {31'd0, out_ch}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_err}, 32'd0);
        chk("rst_frm", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        sck_bit(1'b1, 1'b0, 0);
        sck_bit(1'b1, 1'b0, 0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Left 0x8000 widens to the negative 17-bit value.
        send_word(1'b0, 16'h8000, 1);
        chk("neg_data", {15'd0, out_data}, 32'h0001_8000);
        chk("neg_ch", {31'd0, out_ch}, 32'd0);
        out_ready = 1'b1;
        tick();
        clear_obs();

        send_word(1'b1, 16'h7FFF, 0);
        send_word(1'b0, 16'h0001, 0);
        tick();
        pop_chk("pos_max", 32'h0000_7FFF, 32'd1);
        pop_chk("pos_one", 32'h0000_0001, 32'd0);
        chk("pair_ovr", ovr_cnt, 0);
        chk("pair_frm", frm_cnt, 0);

        // Short frame: ws flips after 10 bits.
        clear_obs();
        sck_bit(1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) sck_bit(1'b1, 1'b1, 0);
        chk("short_noout", q_data.size(), 0);
        send_word(1'b0, 16'hA5C3, 0);
        tick();
        chk("short_frm", frm_cnt, 1);
        pop_chk("after_short", 32'h0001_A5C3, 32'd0);
        chk("short_extra", q_data.size(), 0);

        // Three words into a stalled consumer.
        out_ready = 1'b0;
        clear_obs();
        send_word(1'b1, 16'h1111, 0);
        send_word(1'b0, 16'h2222, 0);
        send_word(1'b1, 16'h3333, 0);
        chk("stall_data", {15'd0, out_data}, 32'h0000_1111);
        chk("stall_ch", {31'd0, out_ch}, 32'd1);
`ifdef PCM_RX_FIFO_EN
        chk("stall_ovr", ovr_cnt, 1);
`else
        chk("stall_ovr", ovr_cnt, 2);
`endif
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        pop_chk("stall_w1", 32'h0000_1111, 32'd1);
`ifdef PCM_RX_FIFO_EN
        pop_chk("stall_w2", 32'h0000_2222, 32'd0);
`endif
        chk("stall_drained", q_data.size(), 0);
        chk("stall_valid", {31'd0, out_valid}, 32'd0);

        // Pop of a full buffer in the same clk as the next word completes.
        clear_obs();
        send_word(1'b0, 16'h4321, 0);
        send_word(1'b1, 16'hFFFF, 2);
        chk("pp_ovr", ovr_cnt, 0);
        pop_chk("pp_old", 32'h0000_4321, 32'd0);
        chk("pp_valid", {31'd0, out_valid}, 32'd1);
        chk("pp_new_data", {15'd0, out_data}, 32'h0001_FFFF);
        chk("pp_new_ch", {31'd0, out_ch}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a word with a sample still buffered.
        send_word(1'b0, 16'h5A5A, 0);
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        sck_bit(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) sck_bit(1'b1, i[0], 0);
        sck = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {15'd0, out_data}, 32'd0);
        chk("mid_rst_ch", {31'd0, out_ch}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_obs();
        for (int i = 0; i < 9; i++) sck_bit(1'b1, 1'b1, 0);
        chk("mid_discard", q_data.size(), 0);
        chk("mid_discard_v", {31'd0, out_valid}, 32'd0);
        send_word(1'b0, 16'hC001, 0);
        tick();
        pop_chk("mid_next", 32'h0001_C001, 32'd0);
        chk("mid_frm", frm_cnt, 0);
        chk("mid_ovr", ovr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
